seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
Multi-cycle signed/unsigned integer multiplier for the EX stage. It is the inverse-operation companion to the EX-stage divider and uses the same request/done/double-width-result interface style. It runs a radix-2 Booth algorithm, one step per clock. While busy it raises a stall request so the pipeline holds. The 2W-bit product feeds the HI/LO write path.

Parameters:
DATA_WIDTH, 32, operand width W; result is 2W bits
CNT_WIDTH, 6, step-counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH+1

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
mul_en  in  1  start request, sampled only in IDLE
signed_mul  in  1  1 = two's-complement operands, 0 = unsigned
operand_1  in  W  multiplicand
operand_2  in  W  multiplier
flush  in  1  pipeline flush; aborts any operation
stall_req  out  1  hold-pipeline request
done  out  1  one-cycle pulse, result valid
result  out  2W  product {hi, lo}; held until next completion

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Reset forces state=IDLE, done=0, result=0, counter=0, and the internal registers to 0. Reset mid-operation abandons the operation with no done pulse.
- States: IDLE, CALC, DONE.
- IDLE:
  - If mul_en=1 and flush=0: latch operands extended to W+1 bits (sign-extend if signed_mul, else zero-extend), clear accumulator and q(-1), counter=0, go to CALC.
  - Otherwise stay in IDLE.
- CALC:
  - One Booth step per cycle on {acc[W+1], mplr[W+1], q(-1)}.
  - Pair (mplr[0], q(-1)): 01 adds the multiplicand, 10 subtracts it, 00/11 do nothing.
  - Then arithmetic-shift the whole register right by 1. counter++.
  - After W+1 steps (counter==W) go to DONE.
- DONE:
  - result <= low 2W bits of {acc, mplr}.
  - done=1 for this cycle only; next state IDLE.
- Latency: mul_en accepted in cycle T gives done=1 in cycle T+W+2 (34 for W=32). Back-to-back: next mul_en is accepted at the earliest in the cycle after DONE.
- stall_req = (IDLE & mul_en & ~flush) | CALC. It is deasserted in DONE so the pipeline advances together with done.
- mul_en in CALC or DONE is ignored and never queued. Operand changes after acceptance are ignored.
- flush in any state: next state IDLE, no done pulse, result unchanged, stall_req=0 the same cycle (combinational). If flush and mul_en arrive together in IDLE, flush wins.
- result changes only on a DONE cycle. Otherwise it holds its last value.
- Arithmetic: all internal add/subtract is W+1 bits wide and wraps modulo 2^(W+1). Product is exact: unsigned max 0xFFFF_FFFE_0000_0001, signed min*min = 0x4000_0000_0000_0000.

Optional Feature:
Macro MUL_EARLY_EXIT_EN.
- Defined: in IDLE, if mul_en=1 and either operand is 0, skip CALC and go straight to DONE with result=0. done arrives in cycle T+1 and stall_req is high only in cycle T.
- Undefined: zero operands take the full W+2-cycle path and produce the same result=0.

Decomposition:
- Shared bus header holds DATA_BUS_WIDTH, DATA_BUS, DOUBLE_DATA_BUS and the state encodings MUL_IDLE/MUL_CALC/MUL_DONE (2-bit).
- One natural combinational sub-module, booth_step: takes acc, mplr, q(-1) and the multiplicand, and returns the next shifted acc, mplr and q(-1). The top module holds the FSM, counter and registers.

Test Plan:
- Unsigned 0xFFFFFFFF*0xFFFFFFFF, mul_en at T -> stall_req high T..T+33, done only at T+34, result=0xFFFFFFFE00000001.
- Signed -7 (0xFFFFFFF9) * 3 -> result=0xFFFFFFFFFFFFFFEB; same bit patterns unsigned -> 0x00000002FFFFFFEB.
- Signed 0x80000000*0x80000000 -> 0x4000000000000000; 0x80000000*0x00000001 -> 0xFFFFFFFF80000000.
- flush at T+10 of an operation -> no done, stall_req=0 that cycle, result keeps prior value; new mul_en at T+12 completes normally at T+46.
- rst_n low at T+5 mid-operation -> result=0, done=0, stall_req=0 immediately; mul_en held high during CALC is never queued.
- 0*5 unsigned -> result=0; done at T+1 with MUL_EARLY_EXIT_EN, at T+34 without.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier_pkg
// Description : Shared bus widths and multiplier state encodings for the
//               EX-stage sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_multiplier_pkg;

    // Native data bus width and the MSB indices of single and double buses
    localparam int DATA_BUS_WIDTH  = 32;
    localparam int DATA_BUS        = DATA_BUS_WIDTH - 1;
    localparam int DOUBLE_DATA_BUS = 2 * DATA_BUS_WIDTH - 1;

    // Multiplier control states
    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_CALC = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/seq_multiplier_booth_step.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier_booth_step
// Description : One radix-2 Booth iteration. Adds, subtracts or skips the
//               multiplicand according to (mplr[0], q(-1)), then shifts the
//               combined {acc, mplr, q(-1)} register arithmetically right by 1.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier_booth_step #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_mplr,
    input  logic             i_q_m1,
    input  logic [WIDTH-1:0] i_mcand,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_mplr,
    output logic             o_q_m1
);

    logic [WIDTH-1:0] w_sum;

    // Booth add/subtract (wraps modulo 2^WIDTH) followed by the arithmetic shift
    always_comb begin
        w_sum = i_acc;
        case ({i_mplr[0], i_q_m1})
            2'b01:   w_sum = i_acc + i_mcand;
            2'b10:   w_sum = i_acc - i_mcand;
            default: w_sum = i_acc;
        endcase
        o_acc  = {w_sum[WIDTH-1], w_sum[WIDTH-1:1]};
        o_mplr = {w_sum[0], i_mplr[WIDTH-1:1]};
        o_q_m1 = i_mplr[0];
    end

endmodule
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Multi-cycle signed/unsigned radix-2 Booth multiplier for the
//               EX stage. One Booth step per clock; stalls the pipeline while
//               busy and pulses done with the 2W-bit {hi, lo} product.
//               Optional macro MUL_EARLY_EXIT_EN: a zero operand skips the
//               Booth iterations and completes in the following cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BUS_WIDTH,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mul_en,
    input  logic                    signed_mul,
    input  logic [DATA_WIDTH-1:0]   operand_1,
    input  logic [DATA_WIDTH-1:0]   operand_2,
    input  logic                    flush,
    output logic                    stall_req,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] result
);

    // Operands are widened by one bit so unsigned values stay positive in Booth
    localparam int                   c_EXT_W     = DATA_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] c_LAST_STEP = CNT_WIDTH'(DATA_WIDTH);

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [CNT_WIDTH-1:0]    r_count;
    logic [c_EXT_W-1:0]      r_acc;
    logic [c_EXT_W-1:0]      r_mplr;
    logic [c_EXT_W-1:0]      r_mcand;
    logic                    r_q_m1;
    logic [2*DATA_WIDTH-1:0] r_result;

    logic [c_EXT_W-1:0]      w_acc_step;
    logic [c_EXT_W-1:0]      w_mplr_step;
    logic                    w_q_step;
    logic [c_EXT_W-1:0]      w_op1_ext;
    logic [c_EXT_W-1:0]      w_op2_ext;
    logic                    w_start;
    logic                    w_skip;
    logic [2*DATA_WIDTH-1:0] w_product;

    assign w_op1_ext = {signed_mul & operand_1[DATA_WIDTH-1], operand_1};
    assign w_op2_ext = {signed_mul & operand_2[DATA_WIDTH-1], operand_2};
    assign w_start   = (r_state == MUL_IDLE) & mul_en & ~flush;

`ifdef MUL_EARLY_EXIT_EN
    assign w_skip = (operand_1 == '0) | (operand_2 == '0);
`else
    assign w_skip = 1'b0;
`endif

    // Low 2W bits of the {acc, mplr} Booth register hold the exact product
    assign w_product = {r_acc[DATA_WIDTH-2:0], r_mplr};

    seq_multiplier_booth_step #(
        .WIDTH (c_EXT_W)
    ) u_booth_step (
        .i_acc   (r_acc),
        .i_mplr  (r_mplr),
        .i_q_m1  (r_q_m1),
        .i_mcand (r_mcand),
        .o_acc   (w_acc_step),
        .o_mplr  (w_mplr_step),
        .o_q_m1  (w_q_step)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MUL_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MUL_IDLE: begin
                if (w_start) begin
                    w_state_next = w_skip ? MUL_DONE : MUL_CALC;
                end
            end
            MUL_CALC: begin
                if (r_count == c_LAST_STEP) begin
                    w_state_next = MUL_DONE;
                end
            end
            MUL_DONE: w_state_next = MUL_IDLE;
            default:  w_state_next = MUL_IDLE;
        endcase
        if (flush) begin
            w_state_next = MUL_IDLE;
        end
    end

    // Booth datapath: load on acceptance, iterate while calculating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_mplr  <= '0;
            r_mcand <= '0;
            r_q_m1  <= 1'b0;
            r_count <= '0;
        end else if (w_start) begin
            r_acc   <= '0;
            r_q_m1  <= 1'b0;
            r_count <= '0;
            r_mcand <= w_op1_ext;
            // A skipped operation must leave a zero product in the register
            r_mplr  <= w_skip ? '0 : w_op2_ext;
        end else if (r_state == MUL_CALC) begin
            r_acc   <= w_acc_step;
            r_mplr  <= w_mplr_step;
            r_q_m1  <= w_q_step;
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    // Result holding register, updated only by a completing DONE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
        end else if ((r_state == MUL_DONE) && !flush) begin
            r_result <= w_product;
        end
    end

    // The product is presented during the done pulse itself, then held
    always_comb begin
        done      = (r_state == MUL_DONE) & ~flush;
        result    = done ? w_product : r_result;
        stall_req = w_start | ((r_state == MUL_CALC) & ~flush);
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_multiplier
// Description : Self-checking scoreboard bench for seq_multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

    localparam int c_W = 32;
`ifdef MUL_EARLY_EXIT_EN
    localparam int c_ZERO_LAT = 1;
`else
    localparam int c_ZERO_LAT = 34;
`endif
    localparam int c_FULL_LAT = 34;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             mul_en     = 1'b0;
    logic             signed_mul = 1'b0;
    logic             flush      = 1'b0;
    logic [c_W-1:0]   operand_1  = '0;
    logic [c_W-1:0]   operand_2  = '0;
    logic             stall_req;
    logic             done;
    logic [2*c_W-1:0] result;

    int               n_checks = 0;
    int               n_pass   = 0;
    logic [63:0]      sb_q[$];

    seq_multiplier #(
        .DATA_WIDTH (c_W),
        .CNT_WIDTH  (6)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mul_en     (mul_en),
        .signed_mul (signed_mul),
        .operand_1  (operand_1),
        .operand_2  (operand_2),
        .flush      (flush),
        .stall_req  (stall_req),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    task automatic score();
        logic [63:0] exp;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
        end else begin
            exp = sb_q.pop_front();
            check("result", result, exp);
        end
    endtask

    // Issue one multiply and follow it to completion, checking latency and stall
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [63:0] exp, input int exp_lat, input logic hold_en);
        logic seen;
        next_cycle();
        mul_en     = 1'b1;
        operand_1  = a;
        operand_2  = b;
        signed_mul = sgn;
        flush      = 1'b0;
        settle();
        check("stall_accept", 64'(stall_req), 64'd1);
        sb_q.push_back(exp);
        seen = 1'b0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            next_cycle();
            mul_en     = hold_en && (c < exp_lat);
            operand_1  = $urandom;
            operand_2  = $urandom;
            signed_mul = 1'($urandom_range(0, 1));
            settle();
            if (done) begin
                seen = 1'b1;
                check("latency", 64'(c), 64'(exp_lat));
                check("stall_at_done", 64'(stall_req), 64'd0);
                score();
            end else if (c < exp_lat) begin
                check("stall_busy", 64'(stall_req), 64'd1);
            end
        end
        if (!seen) begin
            check("done_timeout", 64'd0, 64'd1);
        end
        next_cycle();
        mul_en = 1'b0;
        settle();
        check("done_pulse_len", 64'(done), 64'd0);
        check("result_hold", result, exp);
        check("stall_idle", 64'(stall_req), 64'd0);
    endtask

    initial begin
        logic [63:0] prev;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          late_done;

        // Reset state
        repeat (3) next_cycle();
        settle();
        check("reset_result", result, 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_stall", 64'(stall_req), 64'd0);
        next_cycle();
        rst_n = 1'b1;

        // Spec vectors; the first holds mul_en high during CALC to show no queueing
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, c_FULL_LAT, 1'b1);
        do_op(32'hFFFF_FFF9, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, c_FULL_LAT, 1'b0);
        do_op(32'hFFFF_FFF9, 32'd3, 1'b0, 64'h0000_0002_FFFF_FFEB, c_FULL_LAT, 1'b0);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, c_FULL_LAT, 1'b0);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000, c_FULL_LAT, 1'b0);

        // Flush mid-operation at T+10, new request at T+12
        prev = result;
        next_cycle();
        mul_en = 1'b1; operand_1 = 32'd123; operand_2 = 32'd456; signed_mul = 1'b0;
        settle();
        check("flush_op_stall", 64'(stall_req), 64'd1);
        for (int c = 1; c < 10; c++) begin
            next_cycle();
            mul_en = 1'b0;
            settle();
        end
        next_cycle();
        flush = 1'b1;
        settle();
        check("flush_stall", 64'(stall_req), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_result", result, prev);
        next_cycle();
        flush = 1'b0;
        settle();
        check("post_flush_done", 64'(done), 64'd0);
        check("post_flush_stall", 64'(stall_req), 64'd0);
        do_op(32'd1000, 32'd77, 1'b0, 64'd77000, c_FULL_LAT, 1'b0);

        // Zero operands
        do_op(32'd0, 32'd5, 1'b0, 64'd0, c_ZERO_LAT, 1'b0);
        do_op(32'hDEAD_BEEF, 32'd0, 1'b1, 64'd0, c_ZERO_LAT, 1'b0);

        // Random operands against the reference model
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'(i % 2);
            do_op(ra, rb, rs, model(ra, rb, rs), c_FULL_LAT, 1'b0);
        end

        // Reset at T+5 of an operation abandons it with no done pulse
        next_cycle();
        mul_en = 1'b1; operand_1 = 32'h1234; operand_2 = 32'h5678; signed_mul = 1'b0;
        settle();
        for (int c = 1; c < 5; c++) begin
            next_cycle();
            mul_en = 1'b0;
            settle();
        end
        next_cycle();
        rst_n = 1'b0;
        settle();
        check("rst_mid_result", result, 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_stall", 64'(stall_req), 64'd0);
        next_cycle();
        rst_n = 1'b1;
        late_done = 0;
        for (int c = 0; c < 40; c++) begin
            next_cycle();
            settle();
            if (done) late_done++;
        end
        check("rst_no_done", 64'(late_done), 64'd0);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
